// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   b2b_state_t : converter FSM states
//   BLANK_DIGIT : digit code shown as "all segments off" by display_refresh
//   cnt_w()     : bit-count helper for the shift counter
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} b2b_state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more so
// that the following left shift carries correctly into the next digit.
//   digit_in  : current BCD digit
//   digit_out : corrected digit, ready to be shifted
module add3_digit (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional feature: define B2B_LEAD_BLANK_EN to replace leading zero digits
// (never digit 0) with BLANK_DIGIT in bcd_out.
//
// state | meaning
// IDLE  | waiting for start; bcd_out holds the last result
// SHIFT | one add-3 + shift per clock, BIN_W clocks in total
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   start    : conversion request, honoured only in IDLE
//   bin_in   : unsigned value, captured when start is accepted
//   busy     : high during the BIN_W SHIFT cycles
//   done     : one-cycle pulse, bcd_out updated on this edge
//   bcd_out  : packed BCD result, digit 0 (units) in [3:0]
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = cnt_w(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if ((10 ** DIGITS) <= (2 ** BIN_W) - 1) begin : g_range_err
    $error("bin2bcd_seq: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, BIN_W);
  end

  b2b_state_t       state, next_state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [BIN_W-1:0] bin_next;
  logic [BCD_W-1:0] bcd_final;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    add3_digit u_add3 (
      .digit_in  (bcd_sr[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  // The corrected digits and the remaining binary bits shift as one register.
  assign {bcd_next, bin_next} = {bcd_adj, bin_sr} << 1;

`ifdef B2B_LEAD_BLANK_EN
  always_comb begin
    logic seen_nz;
    bcd_final = bcd_next;
    seen_nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen_nz && (bcd_next[4*i +: 4] == 4'd0)) begin
        bcd_final[4*i +: 4] = BLANK_DIGIT;
      end else begin
        seen_nz = 1'b1;
      end
    end
  end
`else
  assign bcd_final = bcd_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          bin_sr <= bin_next;
          bcd_sr <= bcd_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            bcd_out <= bcd_final;
            done    <= 1'b1;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq. Stimulus pushes the expected BCD word,
// computed from decimal arithmetic, when a start is issued in IDLE; the
// monitor pops and compares on every done pulse. Define B2B_LEAD_BLANK_EN
// for both bench and RTL to check the blanking build.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          done_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Decimal digits straight from division; blanked digits are those above
  // the highest power of ten that the value reaches.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
`ifdef B2B_LEAD_BLANK_EN
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  // Monitor: compare on done, otherwise bcd_out must hold the last result.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_exp = '0;
    end else if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_done: got bcd_out=%h expected no done pulse", bcd_out);
      end else begin
        last_exp = exp_q.pop_front();
        check("bcd_out", bcd_out, last_exp);
      end
    end else begin
      check("bcd_hold", bcd_out, last_exp);
    end
  end

  // Caller is at a negedge with the DUT in IDLE.
  task automatic issue(input int v);
    start  = 1'b1;
    bin_in = 8'(v);
    exp_q.push_back(ref_bcd(v));
  endtask

  // Counts edges from the issuing negedge until done is seen (9 = accept edge
  // plus BIN_W shifts); releases start after the accepting edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) break;
    end
  endtask

  int lat, bn, dc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 255: latency and busy width
    issue(255);
    wait_done(lat, bn);
    check("lat_255", lat, 9);
    check("busy_cycles", bn, 8);
    @(negedge clk);
    check("done_pulse_width", done, 0);

    // zero, then 100
    issue(0);   wait_done(lat, bn);
    @(negedge clk);
    issue(100); wait_done(lat, bn);
    check("lat_100", lat, 9);
    @(negedge clk);

    // start re-pulsed mid-conversion is ignored
    dc = done_cnt;
    issue(42);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; bin_in = 8'd99;
    @(posedge clk); #1 start = 1'b0;
    bin_in = 8'd77;
    wait_done(lat, bn);
    repeat (12) @(negedge clk);
    check("ignored_start_dones", done_cnt - dc, 1);

    // back-to-back: start held in the done cycle
    issue(200);
    wait_done(lat, bn);
    issue(9);
    wait_done(lat, bn);
    check("lat_b2b", lat, 9);
    @(negedge clk);

    // reset mid-conversion
    dc = done_cnt;
    issue(123);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd_out, 0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    reset_n = 1'b1;
    @(negedge clk);
    issue(5);
    wait_done(lat, bn);
    @(negedge clk);

    // random values with random gaps
    for (int n = 0; n < 60; n++) begin
      issue(int'($urandom_range(0, 255)));
      wait_done(lat, bn);
      check("lat_rand", lat, 9);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // exhaustive sweep, issued back-to-back in each done cycle
    @(negedge clk);
    for (int v = 0; v < 256; v++) begin
      issue(v);
      wait_done(lat, bn);
    end
    repeat (3) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
